// File: rtl/det_report.sv
// Detection reporter: FWFT detection FIFO with sticky overflow, per-frame
// person counter, and a hold/blink LED indicator driven by detection activity.
module det_report #(
  parameter int unsigned SW_W      = 11,
  parameter int unsigned N_SW      = 1200,
  parameter int unsigned FIFO_D    = 16,
  parameter int unsigned CNT_W     = 11,
  parameter logic [23:0] HOLD_CYC  = 24'd5_000_000,
  parameter logic [23:0] BLINK_CYC = 24'd500_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic             is_person,
  input  logic [SW_W-1:0]  sw_id,
  input  logic             mode,
  input  logic             clr_ovf,
  input  logic             o_ready,
  output logic             o_valid,
  output logic [SW_W-1:0]  o_sw_id,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             overflow,
  output logic             led
);

  localparam int unsigned   AW       = $clog2(FIFO_D);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_D);
  localparam logic [SW_W-1:0] LAST_ID = SW_W'(N_SW - 1);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_HOLD = 1'b1;

  logic [SW_W-1:0]  mem_q [FIFO_D];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             ovf_q, ovf_d;

  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             frame_done_q, frame_done_d;

  logic             state_q, state_d;
  logic [23:0]      hold_q, hold_d;
  logic [23:0]      blink_q, blink_d;
  logic             phase_q, phase_d;
  logic             led_q, led_d;

  logic             push_att, empty, full, pop, wr_en, drop, is_last;
  logic [CNT_W-1:0] run_inc;

  assign push_att = i_valid & is_person;
  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign pop      = ~empty & o_ready;
  // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
  assign wr_en    = push_att & (~full | pop);
  assign drop     = push_att & full & ~pop;
  assign is_last  = i_valid & (sw_id == LAST_ID);

  assign o_valid    = ~empty;
  assign o_sw_id    = empty ? '0 : mem_q[rd_ptr_q];
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign overflow   = ovf_q;
  assign led        = led_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A new drop wins over a simultaneous clear.
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
  end

  always_comb begin
    run_inc      = (push_att && run_cnt_q != '1) ? run_cnt_q + 1'b1 : run_cnt_q;
    run_cnt_d    = run_inc;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    if (is_last) begin
      frame_cnt_d  = run_inc;
      run_cnt_d    = '0;
      frame_done_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    blink_d = blink_q;
    phase_d = phase_q;
    case (state_q)
      ST_IDLE: begin
        if (push_att) begin
          state_d = ST_HOLD;
          hold_d  = HOLD_CYC - 24'd1;
          blink_d = BLINK_CYC - 24'd1;
          phase_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (blink_q == '0) begin
          phase_d = ~phase_q;
          blink_d = BLINK_CYC - 24'd1;
        end else begin
          blink_d = blink_q - 24'd1;
        end
        if (push_att) begin
          hold_d = HOLD_CYC - 24'd1;
        end else if (hold_q == '0) begin
          state_d = ST_IDLE;
          blink_d = '0;
          phase_d = 1'b0;
        end else begin
          hold_d = hold_q - 24'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Blink phase runs regardless of mode, so switching mode never restarts timing.
    led_d = (state_d == ST_HOLD) & (~mode | phase_d);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= sw_id;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      run_cnt_q    <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      blink_q      <= '0;
      phase_q      <= 1'b0;
      led_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      run_cnt_q    <= run_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
      state_q      <= state_d;
      hold_q       <= hold_d;
      blink_q      <= blink_d;
      phase_q      <= phase_d;
      led_q        <= led_d;
    end
  end

endmodule

// File: tb/tb_det_report.sv
// Directed bench for det_report: FIFO ordering/overflow, frame counting, LED hold and blink.
module tb_det_report;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_valid = 1'b0, is_person = 1'b0, mode = 1'b0, clr_ovf = 1'b0, o_ready = 1'b0;
  logic [5:0] sw_id = '0;

  logic       o_valid, frame_done, overflow, led;
  logic [5:0] o_sw_id;
  logic [3:0] frame_cnt;
  logic       o_valid_b, frame_done_b, overflow_b, led_b;
  logic [5:0] o_sw_id_b;
  logic [3:0] frame_cnt_b;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  det_report #(.SW_W(6), .N_SW(8), .FIFO_D(16), .CNT_W(4),
               .HOLD_CYC(24'd10), .BLINK_CYC(24'd2)) u_dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .is_person(is_person), .sw_id(sw_id),
    .mode(mode), .clr_ovf(clr_ovf), .o_ready(o_ready), .o_valid(o_valid),
    .o_sw_id(o_sw_id), .frame_done(frame_done), .frame_cnt(frame_cnt),
    .overflow(overflow), .led(led));

  det_report #(.SW_W(6), .N_SW(8), .FIFO_D(16), .CNT_W(4),
               .HOLD_CYC(24'd8), .BLINK_CYC(24'd2)) u_blk (
    .clk(clk), .rst(rst), .i_valid(i_valid), .is_person(is_person), .sw_id(sw_id),
    .mode(mode), .clr_ovf(clr_ovf), .o_ready(o_ready), .o_valid(o_valid_b),
    .o_sw_id(o_sw_id_b), .frame_done(frame_done_b), .frame_cnt(frame_cnt_b),
    .overflow(overflow_b), .led(led_b));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; i_valid = 1'b0; is_person = 1'b0; clr_ovf = 1'b0; o_ready = 1'b0; mode = 1'b0;
    tick(); tick();
    rst = 1'b1;
  endtask

  initial begin
    int cnt;
    int pat [9];
    pat = '{1, 1, 0, 0, 1, 1, 0, 0, 0};

    // reset state
    tick(); tick();
    check("rst_o_valid", o_valid, 0);
    check("rst_o_sw_id", o_sw_id, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_overflow", overflow, 0);
    check("rst_led", led, 0);
    rst = 1'b1;

    // push+pop while empty: push stored, no pop
    o_ready = 1'b1; i_valid = 1'b1; is_person = 1'b1; sw_id = 6'd3;
    tick();
    i_valid = 1'b0;
    check("empty_pp_valid", o_valid, 1);
    check("empty_pp_id", o_sw_id, 3);
    tick();
    check("empty_pp_drained", o_valid, 0);

    // 5, 9, 12 with o_ready low, then drain
    o_ready = 1'b0;
    i_valid = 1'b1; sw_id = 6'd5; tick();
    check("fwft_valid", o_valid, 1);
    check("fwft_head", o_sw_id, 5);
    sw_id = 6'd9;  tick();
    sw_id = 6'd12; tick();
    i_valid = 1'b0;
    check("hold_head", o_sw_id, 5);
    o_ready = 1'b1;
    check("drain0", o_sw_id, 5); tick();
    check("drain1", o_sw_id, 9); tick();
    check("drain2", o_sw_id, 12); tick();
    check("drain_empty", o_valid, 0);

    // 17 pushes into a 16-deep FIFO
    do_reset();
    for (int i = 0; i < 17; i++) begin
      i_valid = 1'b1; is_person = 1'b1; sw_id = 6'(10 + i);
      tick();
      if (i == 15) check("ovf_at_full", overflow, 0);
    end
    check("ovf_set", overflow, 1);
    sw_id = 6'd40; clr_ovf = 1'b1;
    tick();
    check("ovf_clr_vs_drop", overflow, 1);
    i_valid = 1'b0;
    tick();
    clr_ovf = 1'b0;
    check("ovf_cleared", overflow, 0);
    o_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("ovf_drain_valid", o_valid, 1);
      check("ovf_drain_id", o_sw_id, 10 + i);
      tick();
    end
    check("ovf_drain_empty", o_valid, 0);

    // full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 16; i++) begin
      i_valid = 1'b1; is_person = 1'b1; sw_id = 6'(30 + i);
      tick();
    end
    o_ready = 1'b1; sw_id = 6'd50;
    tick();
    check("full_pp_no_ovf", overflow, 0);
    o_ready = 1'b0; sw_id = 6'd51;
    tick();
    check("full_pp_still_full", overflow, 1);
    i_valid = 1'b0; o_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("full_pp_id", o_sw_id, (i < 15) ? 31 + i : 50);
      tick();
    end
    check("full_pp_empty", o_valid, 0);

    // frame counting, N_SW = 8
    do_reset();
    o_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      i_valid = 1'b1; sw_id = 6'(i); is_person = (i == 2 || i == 3 || i == 7);
      tick();
      if (i == 6) check("frame_done_early", frame_done, 0);
    end
    i_valid = 1'b0; is_person = 1'b0;
    check("frame_done_pulse", frame_done, 1);
    check("frame_cnt_3", frame_cnt, 3);
    tick();
    check("frame_done_low", frame_done, 0);
    check("frame_cnt_hold", frame_cnt, 3);
    for (int i = 0; i < 8; i++) begin
      i_valid = 1'b1; sw_id = 6'(i); is_person = 1'b0;
      tick();
    end
    i_valid = 1'b0;
    check("frame2_done", frame_done, 1);
    check("frame2_cnt_0", frame_cnt, 0);

    // LED steady, HOLD_CYC = 10
    do_reset();
    o_ready = 1'b1;
    check("led_idle", led, 0);
    i_valid = 1'b1; is_person = 1'b1; sw_id = 6'd1;
    tick();
    i_valid = 1'b0;
    check("led_rise", led, 1);
    cnt = 1;
    for (int c = 1; c <= 25; c++) begin
      tick();
      if (led) cnt++;
    end
    check("led_single_len", cnt, 10);
    i_valid = 1'b1;
    tick();
    cnt = led ? 1 : 0;
    for (int c = 1; c <= 30; c++) begin
      i_valid = (c == 6);
      tick();
      if (led) cnt++;
    end
    check("led_retrigger_len", cnt, 16);

    // LED blink on the HOLD_CYC = 8 instance, then reset mid-hold
    do_reset();
    mode = 1'b1;
    i_valid = 1'b1; is_person = 1'b1; sw_id = 6'd1;
    tick();
    i_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check("blink_pattern", led_b, pat[i]);
      tick();
    end
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    check("midhold_led", led_b, 1);
    check("midhold_valid", o_valid_b, 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_led", led_b, 0);
    check("async_rst_valid", o_valid_b, 0);
    check("async_rst_valid_a", o_valid, 0);
    tick();
    rst = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1);
  end

endmodule

// File: doc/det_report.md
DET_REPORT -- requirements
Module: det_report

Interface
REQ-001 Parameter SW_W, default 11, slide-window index width.
REQ-002 Parameter N_SW, default 1200, windows per frame; sw_id N_SW-1 marks end of frame.
REQ-003 Parameter FIFO_D, default 16 (power of 2), depth of the detection FIFO.
REQ-004 Parameter CNT_W, default 11, width of the per-frame person count.
REQ-005 Parameter HOLD_CYC, default 24'd5_000_000, LED hold time in cycles after the last detection (>=1).
REQ-006 Parameter BLINK_CYC, default 24'd500_000, LED half-period in blink mode (>=1).
REQ-007 clk  in  1  single clock; all logic on rising edge.
REQ-008 rst  in  1  asynchronous, active-low reset.
REQ-009 i_valid  in  1  SVM result strobe, one per window.
REQ-010 is_person  in  1  classification for the current window; sampled only when i_valid=1.
REQ-011 sw_id  in  SW_W  window index for the current result.
REQ-012 mode  in  1  LED mode: 0 steady, 1 blink.
REQ-013 clr_ovf  in  1  clears the sticky overflow flag.
REQ-014 o_ready  in  1  downstream ready for the detection stream.
REQ-015 o_valid  out  1  detection stream valid.
REQ-016 o_sw_id  out  SW_W  window index of the oldest stored detection.
REQ-017 frame_done  out  1  one-cycle end-of-frame pulse.
REQ-018 frame_cnt  out  CNT_W  person count of the last completed frame.
REQ-019 overflow  out  1  sticky: a detection was dropped.
REQ-020 led  out  1  detection indicator.

Function
REQ-021 A push occurs when i_valid=1 and is_person=1; results with is_person=0 are not stored.
REQ-022 The FIFO is first-word fall-through: o_valid=!empty and o_sw_id=head entry; a pop occurs when o_valid=1 and o_ready=1.
REQ-023 Latency from a push into an empty FIFO to o_valid=1 is one cycle.
REQ-024 Push while full without a simultaneous pop is dropped: FIFO unchanged, overflow set the next cycle.
REQ-025 Push and pop in the same cycle while full are both accepted; occupancy is unchanged and no overflow is flagged.
REQ-026 Push and pop in the same cycle while empty: the pop does not occur (o_valid=0), the push is stored.
REQ-027 Read and write pointers wrap modulo FIFO_D; occupancy counter is log2(FIFO_D)+1 bits.
REQ-028 overflow stays 1 until clr_ovf=1; clr_ovf and a new drop in the same cycle leave overflow=1.
REQ-029 A per-frame counter increments on each push attempt (including dropped ones) and saturates at 2^CNT_W-1.
REQ-030 When i_valid=1 and sw_id=N_SW-1: frame_done=1 the next cycle; frame_cnt loads the count including that cycle's result; the running count returns to 0.
REQ-031 frame_cnt holds its value between frame ends; frame_done is 0 in all other cycles.
REQ-032 LED FSM states: IDLE, HOLD. IDLE -> HOLD on push attempt; HOLD -> IDLE when hold counter reaches 0.
REQ-033 Entering HOLD or a push attempt in HOLD loads the hold counter with HOLD_CYC-1; it decrements by 1 each HOLD cycle without a push attempt.
REQ-034 mode=0: led=1 throughout HOLD; mode=1: led starts at 1 on HOLD entry and toggles every BLINK_CYC cycles; led=0 in IDLE.
REQ-035 led is registered: it rises the cycle after the first push attempt.
REQ-036 A mode change takes effect the next cycle without restarting the hold counter.

Reset
REQ-037 While rst=0: FIFO empty, pointers 0, o_valid=0, o_sw_id=0, frame_done=0, frame_cnt=0, overflow=0, led=0, FSM=IDLE, all counters 0.
REQ-038 Reset asserted mid-frame or mid-hold discards stored detections and the partial frame count; operation resumes on the first edge after rst=1.

Verification
REQ-039 Push sw_id 5, 9, 12 with o_ready=0 -> o_valid=1 one cycle after the first push, o_sw_id=5; raise o_ready -> outputs 5, 9, 12 on consecutive cycles, then o_valid=0.
REQ-040 FIFO_D=16, o_ready=0, 17 pushes -> 17th dropped, overflow=1; clr_ovf pulse -> overflow=0; drain returns exactly the first 16 ids in order.
REQ-041 Full FIFO with o_ready=1 and a push in the same cycle -> occupancy stays 16, overflow stays 0.
REQ-042 Frame of N_SW=8 results with is_person=1 at ids 2, 3, 7 -> frame_done pulse one cycle after id 7, frame_cnt=3; next frame with no persons -> frame_cnt=0.
REQ-043 HOLD_CYC=10, mode=0, single detection -> led high for exactly 10 cycles; second detection at cycle 6 -> led high until 10 cycles after it.
REQ-044 mode=1, BLINK_CYC=2, HOLD_CYC=8 -> led pattern 1,1,0,0,1,1,0,0 then 0; rst=0 asserted mid-hold -> led=0 and o_valid=0 immediately.
